// File: rtl/csd_conv_arbiter_pkg.sv
// Shared types, default parameters and helpers for the CSD conversion arbiter.
package csd_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StRead,
        StDrain
    } arb_state_e;

    localparam int unsigned DefNReq     = 4;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefAddrW    = 4;
    localparam int unsigned DefResWords = 9;
    localparam int unsigned DefTimeout  = 255;

    function automatic int unsigned id_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csd_conv_arbiter_if.sv
// Requester, response and engine-side signals of the arbiter; master is the arbiter side.
interface csd_conv_arbiter_if #(
    parameter int unsigned N_REQ  = csd_arb_pkg::DefNReq,
    parameter int unsigned DATA_W = csd_arb_pkg::DefDataW,
    parameter int unsigned ADDR_W = csd_arb_pkg::DefAddrW
);
    localparam int unsigned IdW = csd_arb_pkg::id_w(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_din;
    logic                    eng_done;
    logic                    eng_re;
    logic [ADDR_W-1:0]       eng_addr;
    logic [DATA_W-1:0]       eng_dout;
    logic                    rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [IdW-1:0]          rsp_id;
    logic                    rsp_last;
    logic                    rsp_err;

    modport master (
        input  req, req_data, eng_done, eng_dout,
        output grant, busy, eng_start, eng_din, eng_re, eng_addr,
               rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );

    modport slave (
        output req, req_data, eng_done, eng_dout,
        input  grant, busy, eng_start, eng_din, eng_re, eng_addr,
               rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );

endinterface

// File: rtl/csd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr_i wins.
module rr_pick
    import csd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    localparam int unsigned IdW  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IdW-1:0]   idx_o,
    output logic             any_o
);

    logic [IdW-1:0] cand;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IdW'((32'(ptr_i) + k) % N_REQ);
            if (!any_o && req_i[cand]) begin
                win_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csd_conv_arbiter.sv
// Shares one CSD/ASD conversion engine among N_REQ requesters: round-robin grant,
// launch, wait for done (with timeout) and stream the result memory back to the winner.
module csd_conv_arbiter
    import csd_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DefNReq,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned RES_WORDS = DefResWords,
    parameter int unsigned TIMEOUT   = DefTimeout
) (
    input logic                clk,
    input logic                reset,
    csd_conv_arbiter_if.master bus
);

    localparam int unsigned IdW  = id_w(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RES_WORDS - 1);
    localparam logic [CntW-1:0]   CntMax   = CntW'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  pick_win;
    logic [IdW-1:0]    pick_idx;
    logic              pick_any;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        din_d       = din_q;
        start_d     = 1'b0;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StLaunch;
                    grant_d = pick_win;
                    id_d    = pick_idx;
                    din_d   = bus.req_data[pick_idx*DATA_W +: DATA_W];
                    start_d = 1'b1;
                    ptr_d   = (pick_idx == IdW'(N_REQ - 1)) ? '0 : pick_idx + IdW'(1);
                end
            end
            StLaunch: begin
                // cnt_q counts cycles elapsed since the eng_start cycle
                cnt_d   = CntW'(1);
                state_d = StWait;
            end
            StWait: begin
                if (bus.eng_done) begin
                    state_d = StRead;
                    addr_d  = '0;
                end else if (cnt_q == CntMax) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRead: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.eng_dout;
                rsp_last_d  = (addr_q == LastAddr);
                addr_d      = addr_q + ADDR_W'(1);
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Final word is on the response port this cycle; release afterwards
                state_d = StIdle;
                grant_d = '0;
                addr_d  = '0;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            din_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            din_q       <= din_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = start_q;
    assign bus.eng_din   = din_q;
    assign bus.eng_re    = (state_q == StRead);
    assign bus.eng_addr  = (state_q == StRead) ? addr_q : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
